// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment scanner.
// Walks N_DIGITS common-anode digits, one slot of CLK_DIV clocks per digit,
// with a one-cycle blanking guard at the start of each slot and a free-running
// PWM counter that dims the selected anode. New data is double-buffered:
// a load lands in a shadow register and is promoted to the active register
// only at the frame wrap, so a frame is never drawn from two different values.
// Optional feature macro: SEVSEG_LZ_BLANK_EN (leading-zero blanking).
module seven_seg_scanner #(
  parameter int N_DIGITS = 8,
  parameter int CLK_DIV  = 100000,
  parameter int PWM_BITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*N_DIGITS-1:0]   data_in,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic                    load,
  input  logic [PWM_BITS-1:0]     brightness,
  output logic [6:0]              segments,
  output logic                    dp_n,
  output logic [7:0]              anodes,
  output logic                    frame_done
);

  localparam int              PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [2:0]      IDX_MAX   = 3'(N_DIGITS - 1);

  // Scan timing state
  logic [PW-1:0]           presc_q, presc_d;
  logic [2:0]              idx_q, idx_d;
  logic [PWM_BITS-1:0]     pwm_q, pwm_d;

  // Double-buffered display data
  logic [4*N_DIGITS-1:0]   shadow_data_q, shadow_data_d;
  logic [N_DIGITS-1:0]     shadow_dp_q, shadow_dp_d;
  logic [4*N_DIGITS-1:0]   act_data_q, act_data_d;
  logic [N_DIGITS-1:0]     act_dp_q, act_dp_d;
  logic                    pend_q, pend_d;

  // Registered outputs
  logic [6:0]              seg_q, seg_d;
  logic                    dp_n_q, dp_n_d;
  logic [7:0]              an_q, an_d;
  logic                    frame_done_q, frame_done_d;

  logic                    tick;
  logic                    wrap_tick;
  logic [31:0]             act_ext;
  logic [7:0]              dp_ext;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    blank;

  // Standard hex glyphs, {a,b,c,d,e,f,g}, a 0 lights the segment.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Prescaler, digit index and PWM counter; the wrapping tick closes a frame.
  always_comb begin
    tick      = (presc_q == PRESC_MAX);
    wrap_tick = tick && (idx_q == IDX_MAX);
    presc_d   = tick ? '0 : presc_q + PW'(1);
    idx_d     = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_MAX) ? 3'd0 : idx_q + 3'd1;
    end
    pwm_d     = pwm_q + PWM_BITS'(1);
  end

  // Load into shadow, promote to active only at the frame wrap; a load landing
  // on the wrap itself skips the shadow so it shows in the very next frame.
  always_comb begin
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    act_data_d    = act_data_q;
    act_dp_d      = act_dp_q;
    pend_d        = pend_q;
    if (load) begin
      if (wrap_tick) begin
        act_data_d = data_in;
        act_dp_d   = dp_in;
        pend_d     = 1'b0;
      end else begin
        shadow_data_d = data_in;
        shadow_dp_d   = dp_in;
        pend_d        = 1'b1;
      end
    end else if (wrap_tick && pend_q) begin
      act_data_d = shadow_data_q;
      act_dp_d   = shadow_dp_q;
      pend_d     = 1'b0;
    end
  end

  // Pad the active data to eight digits so the index select never runs off the end.
  always_comb begin
    act_ext                   = '0;
    act_ext[4*N_DIGITS-1:0]   = act_data_q;
    dp_ext                    = '0;
    dp_ext[N_DIGITS-1:0]      = act_dp_q;
    cur_nib                   = act_ext[{idx_q, 2'b00} +: 4];
    cur_dp                    = dp_ext[idx_q];
  end

`ifdef SEVSEG_LZ_BLANK_EN
  // lz[k]: digits k..7 are all zero with no decimal point (padding counts as zero).
  logic [8:0] lz;
  always_comb begin
    lz = '1;
    for (int k = 7; k >= 1; k--) begin
      lz[k] = (act_ext[4*k +: 4] == 4'h0) && !dp_ext[k] && lz[k+1];
    end
  end
  assign blank = (idx_q != 3'd0) && lz[idx_q];
`else
  assign blank = 1'b0;
`endif

  // Next output values: segments always show the decoded digit, anodes do the gating.
  always_comb begin
    seg_d        = hex_to_seg(cur_nib);
    dp_n_d       = ~cur_dp;
    an_d         = 8'hFF;
    if ((presc_q != '0) && (pwm_q <= brightness) && !blank) begin
      an_d[idx_q] = 1'b0;
    end
    frame_done_d = wrap_tick;
  end

  // All state and output registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q       <= '0;
      idx_q         <= '0;
      pwm_q         <= '0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      act_data_q    <= '0;
      act_dp_q      <= '0;
      pend_q        <= 1'b0;
      seg_q         <= 7'h7F;
      dp_n_q        <= 1'b1;
      an_q          <= 8'hFF;
      frame_done_q  <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      pwm_q         <= pwm_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      act_data_q    <= act_data_d;
      act_dp_q      <= act_dp_d;
      pend_q        <= pend_d;
      seg_q         <= seg_d;
      dp_n_q        <= dp_n_d;
      an_q          <= an_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign segments   = seg_q;
  assign dp_n       = dp_n_q;
  assign anodes     = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 Parameter N_DIGITS, default 8, number of scanned digits; legal range 1..8.
REQ-002 Parameter CLK_DIV, default 100000, clk cycles per digit slot; legal minimum 4.
REQ-003 Parameter PWM_BITS, default 4, width of the brightness control.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 data_in  input  4*N_DIGITS  hex nibbles; nibble k drives digit k, nibble 0 is the LSB.
REQ-007 dp_in  input  N_DIGITS  decimal point per digit, 1 = lit.
REQ-008 load  input  1  one-cycle strobe that captures data_in and dp_in.
REQ-009 brightness  input  PWM_BITS  duty setting; all-ones = full on.
REQ-010 segments  output  7  {a,b,c,d,e,f,g}, active-low, registered.
REQ-011 dp_n  output  1  decimal point, active-low, registered.
REQ-012 anodes  output  8  one-cold digit select, active-low, registered; bits N_DIGITS..7 held 1.
REQ-013 frame_done  output  1  one-cycle pulse at the end of each full scan.

Function
REQ-014 Prescaler counts 0..CLK_DIV-1 and wraps to 0; tick is asserted when count = CLK_DIV-1.
REQ-015 Digit index advances by 1 on tick and wraps from N_DIGITS-1 to 0; frame_done is asserted in the cycle after the wrapping tick.
REQ-016 On load, data_in and dp_in are stored in a shadow register and a pending flag is set.
REQ-017 On the wrapping tick with pending set, shadow is copied to the active register and pending is cleared, so the display never tears mid-frame.
REQ-018 If load coincides with the wrapping tick, data_in/dp_in go straight to the active register and pending is cleared.
REQ-019 Repeated loads before a frame boundary overwrite the shadow; the last value wins.
REQ-020 Segment decode is 0-F standard hex, active-low, with the same glyphs as the existing driver (for example, 0 = 0000001 and F = 0111000).
REQ-021 Outputs are registered, with one clk of latency from the index or active-register change to segments/anodes/dp_n.
REQ-022 Guard blanking: anodes are all 1 while the prescaler count = 0 (anti-ghosting).
REQ-023 A free-running PWM_BITS counter increments every clk; the selected anode is driven 0 only when pwm_cnt <= brightness, and is 1 otherwise.
REQ-024 When an anode is off, segments remain the decoded value; only the anodes gate the display.

Reset
REQ-025 Reset forces: segments = 7'h7F, dp_n = 1, anodes = 8'hFF, frame_done = 0.
REQ-026 Reset clears the prescaler, digit index, PWM counter, shadow register, active register and pending flag.
REQ-027 Reset asserted mid-frame takes effect at the next edge, and scanning restarts from digit 0 with a full slot.

Configuration
REQ-028 Macro SEVSEG_LZ_BLANK_EN defined: leading-zero blanking is enabled.
  - Digit k > 0 has its anode forced to 1 when the active nibbles k..N_DIGITS-1 are all zero and their dp bits are all 0.
  - Digit 0 is never blanked.
REQ-029 Macro SEVSEG_LZ_BLANK_EN undefined: every digit 0..N_DIGITS-1 is displayed, and no blanking logic is present.

Verification
REQ-030 Reset scan test.
  - Setup: N_DIGITS=8, CLK_DIV=4, brightness=all-ones.
  - Stimulus: release reset.
  - Response: anodes step FE,FD,...,7F, one slot per 4 clk, each slot with 1 guard cycle of FF; frame_done pulses once per 32 clk.
REQ-031 Tear-free load test.
  - Stimulus: load 32'h0123ABCD in the middle of slot 3.
  - Response: the old value persists until frame wrap; then digit 0 shows 1000010 (d) and digit 7 shows 0000001.
REQ-032 Coincident load/wrap test.
  - Stimulus: load asserted on the wrapping tick.
  - Response: the new value is visible in digit 0 of the very next frame, and pending = 0.
REQ-033 Brightness test.
  - Setup: PWM_BITS=4, brightness=3.
  - Response: the selected anode is low 4 of every 16 clk (excluding guard cycles); with brightness=15 it is always low.
REQ-034 Small-configuration test.
  - Setup: N_DIGITS=4.
  - Response: anodes[7:4] stay 1 throughout; the index wraps 3->0; frame_done pulses every 4*CLK_DIV clk.
REQ-035 Blanking test, with SEVSEG_LZ_BLANK_EN defined.
  - Stimulus: data 32'h00000050, dp_in = 0.
  - Response: only digits 0 and 1 ever drive their anodes low.
  - Without the macro, all 8 digits drive their anodes low.
